// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the EX-stage pipeline controller and the
// multiply/divide unit: start/oper/operands in, busy/done/HI/LO out.
interface mips_muldiv_if;
    logic        start;
    logic [2:0]  oper;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // start is sampled on a rising edge and taken only while busy is low;
    // no ready/queue exists, so a start seen while busy is simply dropped.
    // done pulses for one cycle in the cycle hi/lo first show the new result.
    modport master (output start, oper, a, b, input busy, done, hi, lo);
    modport slave  (input start, oper, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv.sv
// MIPS multiply/divide unit owning HI/LO: iterative shift-add multiply, restoring divide, MTHI/MTLO.
// Build option MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module mips_muldiv (
    input  logic              clk,
    input  logic              rst_n,
    mips_muldiv_if.slave      bus,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        div_ge;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    assign signed_op = (bus.oper == OP_MULT) || (bus.oper == OP_DIV);
    assign a_neg     = signed_op & bus.a[31];
    assign b_neg     = signed_op & bus.b[31];
    assign a_abs     = a_neg ? (32'd0 - bus.a) : bus.a;
    assign b_abs     = b_neg ? (32'd0 - bus.b) : bus.b;

    // Multiply: acc[31:0] holds the remaining multiplier bits, acc[63:32] the partial sum.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

    // Divide: acc[63:32] is the partial remainder, acc[31:0] shifts dividend out / quotient in.
    assign rem_sh    = acc_q[63:31];
    assign div_ge    = rem_sh >= {1'b0, opnd_q};
    assign rem_sub   = rem_sh[31:0] - opnd_q;

    assign prod_fix  = neg_res_q ? (64'd0 - acc_q) : acc_q;
    assign quot_fix  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix   = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_a, fast_b, fast_prod;
    assign fast_a    = (bus.oper == OP_MULT) ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
    assign fast_b    = (bus.oper == OP_MULT) ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
    assign fast_prod = fast_a * fast_b;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.oper)
`ifdef MULDIV_FAST_MUL_EN
                        OP_MULT, OP_MULTU: begin
                            hi_d   = fast_prod[63:32];
                            lo_d   = fast_prod[31:0];
                            done_d = 1'b1;
                        end
`else
                        OP_MULT, OP_MULTU: begin
                            state_d   = S_CALC;
                            cnt_d     = 5'd0;
                            is_div_d  = 1'b0;
                            acc_d     = {32'd0, b_abs};
                            opnd_d    = a_abs;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            div0_d    = 1'b0;
                            a_raw_d   = bus.a;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            state_d   = S_CALC;
                            cnt_d     = 5'd0;
                            is_div_d  = 1'b1;
                            acc_d     = {32'd0, a_abs};
                            opnd_d    = b_abs;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            div0_d    = (bus.b == 32'd0);
                            a_raw_d   = bus.a;
                        end
                        OP_MTHI: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = {(div_ge ? rem_sub : rem_sh[31:0]), acc_q[30:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (div0_q) begin
                    // Divide-by-zero reports the raw dividend, bypassing sign correction.
                    hi_d = a_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_raw_q   <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed corner cases plus random ops against
// an arithmetic reference model (64-bit products, native division with MIPS rules).
module tb_mips_muldiv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_muldiv_if bus ();
  logic [1:0] dbg_state;

  mips_muldiv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {hi, lo} after the op.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, cur_lo};
      3'd5: return {cur_hi, a};
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  function automatic bit is_iter(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3) || (!FAST && (op == 3'd0 || op == 3'd1));
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.oper  = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.oper  = 3'($urandom_range(0, 7));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // n counts cycles since start was raised; done seen at n means done arrived n cycles later.
  task automatic wait_done(input bit exp_busy, input int n0, output int n);
    n = n0;
    if (n == 1) check("busy_after_accept", 64'(bus.busy), 64'(exp_busy));
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 10 && exp_busy) check("hilo_hold_calc", {bus.hi, bus.lo}, {m_hi, m_lo});
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n;
    int exp_lat;
    exp = ref_result(op, a, b, m_hi, m_lo);
    exp_q.push_back(exp);
    exp_lat = is_iter(op) ? 34 : 1;
    drive_start(op, a, b);
    wait_done(is_iter(op), 1, n);
    check($sformatf("latency op%0d", op), 64'(n), 64'(exp_lat));
    check($sformatf("result op%0d a=%h b=%h", op, a, b), {bus.hi, bus.lo}, exp_q.pop_front());
    check("busy_at_done", 64'(bus.busy), 64'd0);
    {m_hi, m_lo} = exp;
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    logic [63:0] exp;
    logic [2:0] op;
    logic [31:0] ra, rb;

    bus.start = 1'b0;
    bus.oper  = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_state_idle", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases.
    run_op(3'd0, 32'hFFFF_FFF9, 32'd3);
    check("mult_m7x3", {m_hi, m_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
    check("mult_min_sq", {m_hi, m_lo}, {32'h4000_0000, 32'h0});
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", {m_hi, m_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {m_hi, m_lo}, {32'h0, 32'h8000_0000});
    run_op(3'd3, 32'd5, 32'd0);
    check("divu_by_zero", {m_hi, m_lo}, {32'd5, 32'hFFFF_FFFF});
    run_op(3'd2, 32'hFFFF_FFF7, 32'd0);
    run_op(3'd0, 32'd3, 32'hFFFF_FFFF);
    check("mult_3xm1", {m_hi, m_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(3'd4, 32'hCAFE_0001, 32'd0);

    // DIVU 7/2, then MTLO issued in the done cycle.
    exp = ref_result(3'd3, 32'd7, 32'd2, m_hi, m_lo);
    exp_q.push_back(exp);
    drive_start(3'd3, 32'd7, 32'd2);
    wait_done(1'b1, 1, n);
    check("divu_7_2_latency", 64'(n), 64'd34);
    check("divu_7_2", {bus.hi, bus.lo}, exp_q.pop_front());
    {m_hi, m_lo} = exp;
    drive_start(3'd5, 32'h1234, 32'd0);
    check("mtlo_in_done_cycle_done", 64'(bus.done), 64'd1);
    check("mtlo_in_done_cycle_hilo", {bus.hi, bus.lo}, {32'd1, 32'h1234});
    m_lo = 32'h1234;
    @(negedge clk);
    check("mtlo_done_one_cycle", 64'(bus.done), 64'd0);

    // Start while busy is dropped.
    exp = ref_result(3'd2, 32'd1000, 32'hFFFF_FFF9, m_hi, m_lo);
    exp_q.push_back(exp);
    drive_start(3'd2, 32'd1000, 32'hFFFF_FFF9);
    repeat (4) @(negedge clk);
    drive_start(3'd2, 32'd5, 32'd1);
    wait_done(1'b1, 6, n);
    check("busy_start_latency", 64'(n), 64'd34);
    check("busy_start_result", {bus.hi, bus.lo}, exp_q.pop_front());
    {m_hi, m_lo} = exp;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("busy_start_no_second_done", 64'(seen), 64'd0);

    // Reserved oper.
    drive_start(3'd6, $urandom, $urandom);
    seen = 1'b0;
    repeat (5) begin
      if (bus.done) seen = 1'b1;
      @(negedge clk);
    end
    check("reserved_no_done", 64'(seen), 64'd0);
    check("reserved_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Reset mid-CALC (DIVU stands in when multiply is single-cycle).
    op = FAST ? 3'd3 : 3'd1;
    drive_start(op, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("midreset_no_done", 64'(seen), 64'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {m_hi, m_lo}, {32'hFFFF_FFFE, 32'h0000_0001});

    // Random ops.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      run_op(op, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Multi-cycle multiply/divide unit for the MIPS CPU's EX stage. It executes MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers, including MTHI/MTLO writes. It runs beside the single-cycle ALU, which handles everything else. The pipeline controller starts an operation with a one-cycle `start` pulse, stalls MFHI/MFLO while `busy` is high, and reads `hi`/`lo` directly.

## Interface
- Parameters: none. Datapath width is fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request; sampled on a rising edge, accepted only when `busy`=0.
- `oper`  input  3  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 and 7 are reserved and ignored.
- `a`  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- `b`  input  32  rt operand: multiplier or divisor.
- `busy`  output  1  iterative operation in progress.
- `done`  output  1  one-cycle pulse; `hi`/`lo` are updated and valid in this cycle.
- `hi`  output  32  HI register.
- `lo`  output  32  LO register.

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: 32 iteration cycles, 5-bit counter.
  - FIX: sign correction and HI/LO writeback.
- Operand capture on acceptance:
  - `a` and `b` are latched, so later input changes have no effect.
  - Signed ops (MULT, DIV) latch absolute values plus result-sign flags.
  - Unsigned ops latch operands as-is.
- Multiply (iterative): radix-2 shift-add over a 64-bit accumulator. FIX negates the 64-bit product if the operand signs differ. Result: `hi`=product[63:32], `lo`=product[31:0].
- Divide: restoring division, one quotient bit per CALC cycle. Result: `lo`=quotient, `hi`=remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- Divide boundary cases:
  - Divisor 0, all divide ops: `lo`=32'hFFFFFFFF, `hi`=`a` (raw, as latched). Latency is unchanged.
  - DIV 32'h80000000 / 32'hFFFFFFFF: `lo`=32'h80000000, `hi`=0.
- MTHI/MTLO: the write occurs on the accepting edge; the other register is unchanged. No CALC/FIX.
- Reserved `oper` with `start`: no state change and no `done`.
- `start` while `busy`=1: ignored. There is no queueing.
- `start` in the same cycle `done`=1: accepted, since `busy` is already 0.
- `rst_n` low at any time, including mid-CALC:
  - Immediately forces IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
  - The in-flight operation is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=32'h0, `lo`=32'h0.
- Iterative op accepted at edge T0:
  - `busy`=1 after edges T0 through T0+32 (33 cycles).
  - CALC runs on edges T0+1 to T0+32.
  - FIX writes HI/LO at edge T0+33.
  - After T0+33: `busy`=0 and `done`=1 for exactly one cycle.
  - Next acceptance is possible at edge T0+33+1.
- MTHI/MTLO accepted at T0: `hi` or `lo` updated after T0, `done`=1 for one cycle, `busy` stays 0.
- `hi`/`lo` never change except at writeback or reset. They hold their old values throughout CALC.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle 64-bit product.
  - Accepted at T0, `hi`/`lo` are written at T0 and `done`=1 in the following cycle; `busy` never asserts.
  - Divide is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: multiply uses the 33-cycle iterative path described above.

## Test plan
- Reset mid-operation:
  - Stimulus: MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF, then drive `rst_n` low at cycle 10 of CALC.
  - Required: `busy`=0 and `hi`=`lo`=0 immediately; no `done`.
  - Repeat without reset. Required: `hi`=32'hFFFFFFFE, `lo`=32'h00000001, and `done` exactly 34 cycles after `start` (iterative build).
- Signed multiply:
  - MULT a=-7, b=3. Required: `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB.
  - MULT a=32'h80000000, b=32'h80000000. Required: `hi`=32'h40000000, `lo`=0.
- Signed divide:
  - DIV a=-7, b=2. Required: `lo`=32'hFFFFFFFD (-3), `hi`=32'hFFFFFFFF (-1).
  - DIVU a=7, b=2. Required: `lo`=3, `hi`=1.
- Divide boundaries:
  - DIV a=32'h80000000, b=32'hFFFFFFFF. Required: `lo`=32'h80000000, `hi`=0.
  - DIVU a=5, b=0. Required: `lo`=32'hFFFFFFFF, `hi`=5, same latency as a normal divide.
- Handshake:
  - Pulse `start` with DIV while `busy`=1. Required: ignored; the first result is unchanged.
  - MTLO a=32'h1234 issued in the `done` cycle. Required: accepted; `lo`=32'h1234 one cycle later; `hi` unchanged.
  - `oper`=6. Required: no `done`, `hi`/`lo` unchanged.
- With `MULDIV_FAST_MUL_EN` defined:
  - MULT a=3, b=-1. Required: `done` one cycle after `start`, `busy` never 1, `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFFD.
